// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding entry per execution unit, round-robin
// selection of a pending entry, and a registered single-result broadcast.
module cdb_arbiter #(
    parameter int unsigned N_UNITS   = 4,
    parameter int unsigned ROB_IDX_W = 5,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [N_UNITS-1:0]            ex_valid,
    input  logic [N_UNITS*ROB_IDX_W-1:0]  ex_rob_id,
    input  logic [N_UNITS*DATA_W-1:0]     ex_data,
    output logic [N_UNITS-1:0]            ex_accept,
    output logic                          cdb_valid,
    output logic [ROB_IDX_W-1:0]          cdb_rob_id,
    output logic [DATA_W-1:0]             cdb_data
);

    localparam int unsigned PtrW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

    logic [N_UNITS-1:0]   pending_q;
    logic [ROB_IDX_W-1:0] ent_rob_q  [N_UNITS];
    logic [DATA_W-1:0]    ent_data_q [N_UNITS];
    logic [PtrW-1:0]      rr_ptr_q;

    logic [N_UNITS-1:0]   grant;
    logic [PtrW-1:0]      grant_idx;
    logic                 grant_any;
    logic [PtrW-1:0]      rr_ptr_next;
    logic [N_UNITS-1:0]   load;

    // Round-robin pick: first pending entry at or after rr_ptr, wrapping.
    always_comb begin
        logic [PtrW-1:0] cand;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < N_UNITS; k++) begin
            cand = PtrW'((32'(rr_ptr_q) + k) % N_UNITS);
            if (!grant_any && pending_q[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_any   = 1'b1;
            end
        end
        rr_ptr_next = PtrW'((32'(grant_idx) + 32'd1) % N_UNITS);
    end

    // A unit may hand over a result if its entry is free or drains this cycle.
    always_comb begin
        ex_accept = (~pending_q | grant) & {N_UNITS{~flush}};
        load      = ex_valid & ex_accept;
    end

    // Holding entries: reload wins over grant-clear, flush wipes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            for (int i = 0; i < N_UNITS; i++) begin
                ent_rob_q[i]  <= '0;
                ent_data_q[i] <= '0;
            end
        end else if (flush) begin
            pending_q <= '0;
        end else begin
            for (int i = 0; i < N_UNITS; i++) begin
                if (load[i]) begin
                    pending_q[i]  <= 1'b1;
                    ent_rob_q[i]  <= ex_rob_id[i*ROB_IDX_W +: ROB_IDX_W];
                    ent_data_q[i] <= ex_data[i*DATA_W +: DATA_W];
                end else if (grant[i]) begin
                    pending_q[i] <= 1'b0;
                end
            end
        end
    end

    // Broadcast register and round-robin pointer; payload holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid  <= 1'b0;
            cdb_rob_id <= '0;
            cdb_data   <= '0;
            rr_ptr_q   <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else if (grant_any) begin
            cdb_valid  <= 1'b1;
            cdb_rob_id <= ent_rob_q[grant_idx];
            cdb_data   <= ent_data_q[grant_idx];
            rr_ptr_q   <= rr_ptr_next;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic
// compared against a behavioural round-robin model.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int RW = 5;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [N-1:0]      ex_valid;
    logic [N*RW-1:0]   ex_rob_id;
    logic [N*DW-1:0]   ex_data;
    logic [N-1:0]      ex_accept;
    logic              cdb_valid;
    logic [RW-1:0]     cdb_rob_id;
    logic [DW-1:0]     cdb_data;

    logic [N-1:0]      drv_v;
    logic [RW-1:0]     drv_rob  [N];
    logic [DW-1:0]     drv_data [N];
    logic [N-1:0]      acc_last;

    // Behavioural model state
    bit                m_pend [N];
    logic [RW-1:0]     m_rob  [N];
    logic [DW-1:0]     m_data [N];
    int                m_ptr;
    logic              m_cv;
    logic [RW-1:0]     m_crob;
    logic [DW-1:0]     m_cdata;

    int n_cmp = 0;
    int n_err = 0;

    cdb_arbiter #(
        .N_UNITS   (N),
        .ROB_IDX_W (RW),
        .DATA_W    (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_rob_id  (ex_rob_id),
        .ex_data    (ex_data),
        .ex_accept  (ex_accept),
        .cdb_valid  (cdb_valid),
        .cdb_rob_id (cdb_rob_id),
        .cdb_data   (cdb_data)
    );

    always #5 clk = ~clk;

    // Pack per-unit drive values onto the flat buses
    always_comb begin
        ex_valid  = drv_v;
        ex_rob_id = '0;
        ex_data   = '0;
        for (int i = 0; i < N; i++) begin
            ex_rob_id[i*RW +: RW] = drv_rob[i];
            ex_data[i*DW +: DW]   = drv_data[i];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_winner();
        for (int k = 0; k < N; k++) begin
            int u;
            u = (m_ptr + k) % N;
            if (m_pend[u]) return u;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_rob[i]  = '0;
            m_data[i] = '0;
        end
        m_ptr    = 0;
        m_cv     = 1'b0;
        m_crob   = '0;
        m_cdata  = '0;
        acc_last = '0;
    endtask

    // One clock cycle: inputs already driven; check accept, then outputs after the edge
    task automatic step();
        int           w;
        logic [N-1:0] exp_acc;
        #1;
        w = model_winner();
        for (int i = 0; i < N; i++)
            exp_acc[i] = ((!m_pend[i]) || (w == i)) && !flush;
        check("ex_accept", {60'd0, ex_accept}, {60'd0, exp_acc});
        @(posedge clk);
        if (flush) begin
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
            m_cv = 1'b0;
        end else begin
            if (w >= 0) begin
                m_cv      = 1'b1;
                m_crob    = m_rob[w];
                m_cdata   = m_data[w];
                m_ptr     = (w + 1) % N;
                m_pend[w] = 1'b0;
            end else begin
                m_cv = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (drv_v[i] && exp_acc[i]) begin
                    m_pend[i] = 1'b1;
                    m_rob[i]  = drv_rob[i];
                    m_data[i] = drv_data[i];
                end
            end
        end
        acc_last = drv_v & exp_acc;
        #1;
        check("cdb_valid", {63'd0, cdb_valid}, {63'd0, m_cv});
        check("cdb_rob_id", {59'd0, cdb_rob_id}, {59'd0, m_crob});
        check("cdb_data", {32'd0, cdb_data}, {32'd0, m_cdata});
    endtask

    task automatic tick();
        step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        drv_v = '0;
        flush = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst   = 1'b0;
        flush = 1'b0;
        drv_v = '0;
        for (int i = 0; i < N; i++) begin
            drv_rob[i]  = '0;
            drv_data[i] = '0;
        end
        model_reset();
        #1 rst = 1'b1;
        #1;
        check("rst_valid", {63'd0, cdb_valid}, 64'd0);
        check("rst_rob", {59'd0, cdb_rob_id}, 64'd0);
        check("rst_data", {32'd0, cdb_data}, 64'd0);
        check("rst_accept", {60'd0, ex_accept}, 64'hF);
        flush = 1'b1;
        #1;
        check("rst_flush_accept", {60'd0, ex_accept}, 64'h0);
        flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Single result
        drv_v       = 4'b0001;
        drv_rob[0]  = 5'd3;
        drv_data[0] = 32'hDEADBEEF;
        tick();
        drv_v = '0;
        tick();
        check("single_valid", {63'd0, cdb_valid}, 64'd1);
        check("single_rob", {59'd0, cdb_rob_id}, 64'd3);
        check("single_data", {32'd0, cdb_data}, 64'hDEADBEEF);
        tick();
        check("single_idle", {63'd0, cdb_valid}, 64'd0);

        // Contention from rr_ptr = 0
        do_reset();
        drv_v = 4'b1111;
        for (int i = 0; i < N; i++) begin
            drv_rob[i]  = RW'(i + 1);
            drv_data[i] = $urandom;
        end
        tick();
        drv_v = '0;
        for (int k = 0; k < N; k++) begin
            tick();
            check("cont_valid", {63'd0, cdb_valid}, 64'd1);
            check("cont_rob", {59'd0, cdb_rob_id}, 64'(k + 1));
        end

        // Streaming on unit 2
        drv_v = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            drv_rob[2]  = RW'(k + 8);
            drv_data[2] = $urandom;
            tick();
            check("stream_acc", {63'd0, ex_accept[2]}, 64'd1);
            if (k > 0) check("stream_valid", {63'd0, cdb_valid}, 64'd1);
        end
        drv_v = '0;
        tick();
        check("stream_last", {59'd0, cdb_rob_id}, 64'd15);
        tick();

        // Wrap: rr_ptr is 3 here
        drv_v       = 4'b1001;
        drv_rob[0]  = 5'd10;
        drv_rob[3]  = 5'd13;
        tick();
        drv_v = '0;
        tick();
        check("wrap_first", {59'd0, cdb_rob_id}, 64'd13);
        tick();
        check("wrap_second", {59'd0, cdb_rob_id}, 64'd10);
        drv_v      = 4'b0011;
        drv_rob[0] = 5'd20;
        drv_rob[1] = 5'd21;
        tick();
        drv_v = '0;
        tick();
        check("wrap_ptr1_first", {59'd0, cdb_rob_id}, 64'd21);
        tick();
        check("wrap_ptr1_second", {59'd0, cdb_rob_id}, 64'd20);
        tick();

        // Flush with units 1 and 2 pending
        drv_v      = 4'b0110;
        drv_rob[1] = 5'd6;
        drv_rob[2] = 5'd7;
        tick();
        drv_v = 4'b1111;
        flush = 1'b1;
        #1;
        check("flush_accept", {60'd0, ex_accept}, 64'h0);
        tick();
        drv_v = '0;
        flush = 1'b0;
        check("flush_valid", {63'd0, cdb_valid}, 64'd0);
        tick();
        check("flush_nothing", {63'd0, cdb_valid}, 64'd0);

        // Asynchronous reset during a broadcast
        drv_v       = 4'b0001;
        drv_rob[0]  = 5'd9;
        drv_data[0] = 32'h12345678;
        tick();
        drv_v = '0;
        tick();
        check("arst_pre_valid", {63'd0, cdb_valid}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", {63'd0, cdb_valid}, 64'd0);
        check("arst_rob", {59'd0, cdb_rob_id}, 64'd0);
        check("arst_data", {32'd0, cdb_data}, 64'd0);
        check("arst_accept", {60'd0, ex_accept}, 64'hF);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Random traffic honouring the hold-until-accept protocol
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(drv_v[i] && !acc_last[i])) begin
                    drv_v[i]    = ($urandom_range(0, 99) < 60);
                    drv_rob[i]  = RW'($urandom);
                    drv_data[i] = $urandom;
                end
            end
            flush = ($urandom_range(0, 19) == 0);
            tick();
        end
        flush = 1'b0;
        drv_v = '0;
        for (int c = 0; c < N + 1; c++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter N_UNITS, default 4, number of execution units feeding the common data bus.
REQ-002 Parameter ROB_IDX_W, default 5, ROB index width.
REQ-003 Parameter DATA_W, default 32, result width.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset; asynchronous, active-high.
REQ-006 Port flush  input  1  branch-mispredict squash; synchronous.
REQ-007 Port ex_valid  input  N_UNITS  per-unit result valid.
REQ-008 Port ex_rob_id  input  N_UNITS*ROB_IDX_W  per-unit destination ROB index; unit i occupies slice [i*ROB_IDX_W +: ROB_IDX_W].
REQ-009 Port ex_data  input  N_UNITS*DATA_W  per-unit result value; unit i occupies slice [i*DATA_W +: DATA_W].
REQ-010 Port ex_accept  output  N_UNITS  unit i's result is captured at this edge.
REQ-011 Port cdb_valid  output  1  broadcast valid, registered.
REQ-012 Port cdb_rob_id  output  ROB_IDX_W  broadcast ROB index, registered.
REQ-013 Port cdb_data  output  DATA_W  broadcast value, registered.

Function
REQ-014 Each unit i SHALL have one holding entry: pending[i], rob_id and data.
REQ-015 ex_accept[i] SHALL equal (~pending[i] | grant[i]) & ~flush; it is combinational.
REQ-016 When ex_valid[i] & ex_accept[i], the entry SHALL load ex_rob_id and ex_data and set pending[i] at the edge.
REQ-017 A unit SHALL hold ex_valid, ex_rob_id and ex_data stable until ex_accept[i]; no capture occurs without ex_valid.
REQ-018 Grant selection SHALL be combinational round-robin: grant = the first pending index found scanning rr_ptr, rr_ptr+1, ... mod N_UNITS, one-hot or zero.
REQ-019 On a grant to g, at the edge: cdb_valid<=1, cdb_rob_id and cdb_data <= entry g, rr_ptr <= (g+1) mod N_UNITS.
REQ-020 On a grant to g, pending[g] SHALL be cleared unless it is reloaded in the same cycle per REQ-016.
REQ-021 With no pending entry, cdb_valid SHALL go 0 at the edge; cdb_rob_id, cdb_data and rr_ptr SHALL hold.
REQ-022 Latency: ex_valid accepted at edge t -> cdb_valid at edge t+1 at the earliest. Exactly one broadcast per cycle maximum.
REQ-023 Throughput: a unit continuously granted SHALL sustain one result per cycle (simultaneous grant and reload).
REQ-024 Fairness: a pending entry SHALL be broadcast within N_UNITS cycles of becoming pending.
REQ-025 Flush SHALL, at the edge: clear all pending bits, set cdb_valid to 0, capture nothing, and hold rr_ptr.
REQ-026 Flush has priority over grant and capture in the same cycle.
REQ-027 rr_ptr SHALL wrap from N_UNITS-1 to 0.

Reset
REQ-028 While rst is high, asynchronously: pending all 0, rr_ptr 0, cdb_valid 0, cdb_rob_id 0, cdb_data 0.
REQ-029 While rst is high, ex_accept SHALL be all 1s unless flush is high.
REQ-030 Reset asserted mid-broadcast SHALL drop cdb_valid immediately; held results are discarded.

Verification
REQ-031 Single: after reset, ex_valid=0001, rob_id 3, data 0xDEADBEEF for one cycle -> next cycle cdb_valid=1, rob 3, data 0xDEADBEEF; following cycle cdb_valid=0.
REQ-032 Contention: all four units valid, rob 1..4, rr_ptr=0 -> broadcasts rob 1,2,3,4 on four consecutive cycles; ex_accept=0 for each held unit until its grant.
REQ-033 Streaming: unit 2 valid every cycle, others idle -> cdb_valid continuously 1 with one result per cycle; ex_accept[2] stays 1.
REQ-034 Wrap/fairness: rr_ptr=3, units 0 and 3 pending -> unit 3 granted first, then unit 0; rr_ptr ends at 1.
REQ-035 Flush: units 1 and 2 pending, flush for one cycle -> cdb_valid=0 next cycle, nothing pending, ex_accept=0000 during flush.
REQ-036 Async reset: assert rst between clock edges during a broadcast -> cdb_valid drops to 0 before the next edge; all outputs 0.
